alu_mc: RTL
===========

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter: WIDTH, default 8, datapath width in bits; SHALL be a power of two, 4 to 32.
REQ-002 Parameter: SHW, default $clog2(WIDTH), width of the shift-amount field taken from INPUTB[SHW-1:0].
REQ-003 Port: CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: RESET_N  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: IN_VALID  input  1  operation request present.
REQ-006 Port: IN_READY  output  1  block accepts a request this cycle.
REQ-007 Port: OP  input  4  opcode: 0 ADD, 1 SUB, 2 XOR, 3 AND, 4 SLL, 5 SRL, 6 SRA, 7 MUL; 8-15 illegal.
REQ-008 Port: T  input  1  toggle bit; carry-in for ADD, borrow-in for SUB, ignored otherwise.
REQ-009 Port: INPUTA, INPUTB  input  WIDTH each  operands; INPUTB[SHW-1:0] is the shift amount for SLL/SRL/SRA.
REQ-010 Port: OUT_VALID  output  1  result registers hold a completed result.
REQ-011 Port: OUT_READY  input  1  consumer takes the result this cycle.
REQ-012 Port: OUT, OUT_HI  output  WIDTH each  result low word; high word (MUL only, else 0).
REQ-013 Port: ZERO, CARRY, NEG, ERR  output  1 each  registered flags: OUT==0, carry/borrow out or last bit shifted out, OUT[WIDTH-1], illegal opcode.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY, DONE; IN_READY SHALL be 1 only in IDLE.
REQ-015 Handshake SHALL occur when IN_VALID && IN_READY; operands, OP and T SHALL be captured in that cycle and ignored thereafter until IDLE.
REQ-016 ADD, SUB, XOR, AND and illegal opcodes SHALL go IDLE->DONE, OUT_VALID rising the cycle after acceptance (latency 1).
REQ-017 ADD: {CARRY,OUT} = A + B + T, computed at WIDTH+1 bits.
REQ-018 SUB: {CARRY,OUT} = A - B - T; CARRY = 1 on borrow.
REQ-019 SLL/SRL/SRA SHALL shift one bit per cycle in BUSY for n = INPUTB[SHW-1:0] cycles, then enter DONE (latency n+1); n = 0 SHALL go directly to DONE with OUT = A, CARRY = 0 (latency 1).
REQ-020 SRA SHALL replicate bit WIDTH-1; CARRY SHALL equal the last bit shifted out.
REQ-021 MUL SHALL be unsigned shift-add, one partial product per cycle, exactly WIDTH cycles in BUSY (latency WIDTH+1); {OUT_HI,OUT} = A*B; CARRY = (OUT_HI != 0).
REQ-022 Illegal opcode SHALL produce OUT = 0, OUT_HI = 0, ZERO = 1, ERR = 1; ERR SHALL be 0 for every legal opcode.
REQ-023 ZERO and NEG SHALL derive from the final OUT only, registered with it.
REQ-024 In DONE, OUT, OUT_HI and flags SHALL hold stable while OUT_READY = 0; OUT_READY = 1 SHALL return to IDLE next cycle, OUT_VALID falling.
REQ-025 OUT_READY while not in DONE SHALL have no effect; a result SHALL never be dropped or overwritten before its handshake.
REQ-026 Throughput for latency-1 ops with OUT_READY held high SHALL be one result every 2 cycles.

Reset
REQ-027 RESET_N = 0 SHALL immediately force IDLE, IN_READY = 1 after release, OUT_VALID = 0, OUT = 0, OUT_HI = 0, ZERO = 1, CARRY = 0, NEG = 0, ERR = 0.
REQ-028 Reset asserted in BUSY or DONE SHALL abandon the operation with no result emitted after release.

Configuration
REQ-029 Macro ALU_MC_MUL_EN: defined -> MUL implemented per REQ-021; undefined -> opcode 7 SHALL be treated as illegal per REQ-022 and no multiplier datapath SHALL be synthesised.

Verification
REQ-030 WIDTH=8, ADD A=8'hFF B=8'h01 T=1 -> 1 cycle later OUT_VALID, OUT=8'h01, CARRY=1, ZERO=0.
REQ-031 SUB A=8'h10 B=8'h10 T=0 -> OUT=8'h00, ZERO=1, CARRY=0; then A=8'h00 B=8'h01 -> OUT=8'hFF, CARRY=1, NEG=1.
REQ-032 SRA A=8'h80 B=8'h03 -> OUT_VALID exactly 4 cycles after acceptance, OUT=8'hF0, CARRY=0; SLL B=8'h00 -> latency 1, OUT=A.
REQ-033 MUL A=8'hFF B=8'hFF (macro defined) -> latency 9, OUT_HI=8'hFE, OUT=8'h01, CARRY=1; macro undefined -> latency 1, ERR=1, OUT=0.
REQ-034 Complete ADD with OUT_READY=0 for 5 cycles while IN_VALID=1 with new operands -> IN_READY=0, OUT and flags unchanged, second request accepted only after OUT_READY pulse.
REQ-035 MUL accepted, RESET_N pulsed low at BUSY cycle 3 -> all outputs at reset values, no OUT_VALID after release until a new request.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes; optional MUL via ALU_MC_MUL_EN
module alu_mc #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [3:0]       OP,
  input  logic             T,
  input  logic [WIDTH-1:0] INPUTA,
  input  logic [WIDTH-1:0] INPUTB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] OUT_HI,
  output logic             ZERO,
  output logic             CARRY,
  output logic             NEG,
  output logic             ERR
);
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_SRA = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t           r_state;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_sh;
  logic [SHW:0]     r_cnt;
  logic [SHW-1:0]   w_n;
  logic [WIDTH:0]   w_add, w_sub;
  logic             w_legal, w_is_sh, w_go_busy, w_imm_cy, w_sh_out, w_fin_cy;
  logic [WIDTH-1:0] w_imm, w_sh_nxt, w_fin_out, w_fin_hi;
  // single-cycle results at acceptance and one shift step while busy
  always_comb begin
    w_n       = INPUTB[SHW-1:0];
    w_add     = {1'b0, INPUTA} + {1'b0, INPUTB} + {{WIDTH{1'b0}}, T};
    w_sub     = {1'b0, INPUTA} - {1'b0, INPUTB} - {{WIDTH{1'b0}}, T};
    w_is_sh   = OP == OP_SLL || OP == OP_SRL || OP == OP_SRA;
    w_go_busy = (w_is_sh && w_n != '0) || (w_legal && OP == OP_MUL);
    w_imm     = OP == OP_ADD ? w_add[WIDTH-1:0] :
                OP == OP_SUB ? w_sub[WIDTH-1:0] :
                OP == OP_XOR ? INPUTA ^ INPUTB :
                OP == OP_AND ? INPUTA & INPUTB :
                w_is_sh      ? INPUTA : '0;
    w_imm_cy  = OP == OP_ADD ? w_add[WIDTH] : (OP == OP_SUB && w_sub[WIDTH]);
    w_sh_nxt  = r_op == OP_SLL ? {r_sh[WIDTH-2:0], 1'b0}
                               : {r_op == OP_SRA && r_sh[WIDTH-1], r_sh[WIDTH-1:1]};
    w_sh_out  = r_op == OP_SLL ? r_sh[WIDTH-1] : r_sh[0];
  end
`ifdef ALU_MC_MUL_EN
  logic [WIDTH-1:0] r_a, r_hi;
  logic [WIDTH:0]   w_sum;
  logic             w_mul;
  assign w_legal   = ~OP[3];
  assign w_mul     = r_op == OP_MUL;
  assign w_sum     = {1'b0, r_hi} + (r_sh[0] ? {1'b0, r_a} : '0);
  assign w_fin_out = w_mul ? {w_sum[0], r_sh[WIDTH-1:1]} : w_sh_nxt;
  assign w_fin_hi  = w_mul ? w_sum[WIDTH:1] : '0;
  assign w_fin_cy  = w_mul ? |w_sum[WIDTH:1] : w_sh_out;
  // multiplicand capture and high word of the shift-add accumulator
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_a  <= '0;
      r_hi <= '0;
    end else if (r_state == IDLE) begin
      r_a  <= INPUTA;
      r_hi <= '0;
    end else if (r_state == BUSY) begin
      r_hi <= w_sum[WIDTH:1];
    end
  end
`else
  assign w_legal   = ~OP[3] && OP != OP_MUL;
  assign w_fin_out = w_sh_nxt;
  assign w_fin_hi  = '0;
  assign w_fin_cy  = w_sh_out;
`endif
  // control FSM with registered handshake, result and flags
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_sh      <= '0;
      r_cnt     <= '0;
      IN_READY  <= 1'b1;
      OUT_VALID <= 1'b0;
      OUT       <= '0;
      OUT_HI    <= '0;
      ZERO      <= 1'b1;
      CARRY     <= 1'b0;
      NEG       <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (IN_VALID) begin
          r_op     <= OP;
          r_sh     <= OP == OP_MUL ? INPUTB : INPUTA;
          r_cnt    <= OP == OP_MUL ? (SHW+1)'(WIDTH) : {1'b0, w_n};
          IN_READY <= 1'b0;
          if (w_go_busy) begin
            r_state <= BUSY;
          end else begin
            r_state   <= DONE;
            OUT_VALID <= 1'b1;
            OUT       <= w_imm;
            OUT_HI    <= '0;
            ZERO      <= w_imm == '0;
            CARRY     <= w_imm_cy;
            NEG       <= w_imm[WIDTH-1];
            ERR       <= !w_legal;
          end
        end
        BUSY: begin
          r_sh  <= w_fin_out;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == (SHW+1)'(1)) begin
            r_state   <= DONE;
            OUT_VALID <= 1'b1;
            OUT       <= w_fin_out;
            OUT_HI    <= w_fin_hi;
            ZERO      <= w_fin_out == '0;
            CARRY     <= w_fin_cy;
            NEG       <= w_fin_out[WIDTH-1];
            ERR       <= 1'b0;
          end
        end
        DONE: if (OUT_READY) begin
          r_state   <= IDLE;
          IN_READY  <= 1'b1;
          OUT_VALID <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
